// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared tag encodings and default widths for unified_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int TAG_W          = 2;
  localparam int MEM_AW_DEFAULT = 14;

  typedef enum logic [TAG_W-1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_tag_pipe.sv
// ============================================================================
// Module  : mem_arb_tag_pipe
// Purpose : DEPTH-stage read-owner tag shift register with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage [DEPTH];

  // Free-running shift: the RAM never stalls, so neither does the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module  : unified_mem_arbiter
// Purpose : Shares one single-port RAM between fetch and load/store ports,
//           data port first; optional fetch anti-starvation via macro
//           MEM_ARB_STARVE_GUARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_AW      = MEM_AW_DEFAULT,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STARVE  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic             force_if;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(MAX_STARVE + 1) < 3) ? 3 : $clog2(MAX_STARVE + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Counts consecutive cycles the fetch port waited; any gap or win restarts it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || if_gnt || !if_req) starve_cnt <= '0;
    else                              starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_if = (starve_cnt == CNT_W'(MAX_STARVE)) && if_req;

  logic unused_ok;
  assign unused_ok = &{1'b0, if_addr, d_addr};
`else
  assign force_if = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, if_addr, d_addr, 1'(MAX_STARVE)};
`endif

  assign d_gnt  = !sys_rst && d_req && !force_if;
  assign if_gnt = !sys_rst && if_req && (!d_req || force_if);
  assign mem_en = if_gnt | d_gnt;
  assign mem_we = d_gnt ? d_we : 4'b0;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    tag_in    = TAG_NONE;
    if (d_gnt) begin
      mem_addr  = d_addr[MEM_AW+1:2];
      mem_wdata = d_wdata;
      tag_in    = (d_we == 4'b0) ? TAG_D : TAG_NONE;
    end else if (if_gnt) begin
      mem_addr  = if_addr[MEM_AW+1:2];
      tag_in    = TAG_IF;
    end
  end

  mem_arb_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Read data bypasses straight from the RAM; rvalid names the owner.
  assign if_rvalid = (tag_out == TAG_IF);
  assign d_rvalid  = (tag_out == TAG_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Purpose : Directed checks of unified_mem_arbiter at MEM_LATENCY 1 and 2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_we;
  logic [13:0] a_mem_addr;

  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_we;
  logic [13:0] b_mem_addr;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  unified_mem_arbiter #(.MEM_LATENCY(2)) u_dut2 (
    .sys_clk(clk), .sys_rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Behavioural RAMs, word i preloaded with 0xA0000000 + i.
  logic [31:0] ram1 [256];
  logic [31:0] ram2 [256];
  logic [31:0] ram2_s1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram1[i] = 32'hA000_0000 + i;
      ram2[i] = 32'hA000_0000 + i;
    end
  end

  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we == 4'b0) a_mem_rdata <= ram1[a_mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (a_mem_we[b]) ram1[a_mem_addr[7:0]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (b_mem_en) begin
      if (b_mem_we == 4'b0) ram2_s1 <= ram2[b_mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (b_mem_we[b]) ram2[b_mem_addr[7:0]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
    end
    b_mem_rdata <= ram2_s1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the edge, return at the negedge.
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset with both ports requesting
    drive(1'b1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
    chk("rst_if_gnt", a_if_gnt, 0);
    chk("rst_d_gnt", a_d_gnt, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_rvalid", {b_if_rvalid, b_d_rvalid, a_if_rvalid, a_d_rvalid}, 0);

    // Fetch stream 0x0, 0x4, 0x8 at latency 1
    drive(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("f0_if_gnt", a_if_gnt, 1);
    chk("f0_mem_addr", 32'(a_mem_addr), 0);
    chk("f0_if_rvalid", a_if_rvalid, 0);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("f1_if_gnt", a_if_gnt, 1);
    chk("f1_if_rvalid", a_if_rvalid, 1);
    chk("f1_if_rdata", a_if_rdata, 32'hA000_0000);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("f2_if_gnt", a_if_gnt, 1);
    chk("f2_if_rdata", a_if_rdata, 32'hA000_0001);
    chk("f2_d_rvalid", a_d_rvalid, 0);
    idle();
    chk("f3_if_gnt", a_if_gnt, 0);
    chk("f3_if_rvalid", a_if_rvalid, 1);
    chk("f3_if_rdata", a_if_rdata, 32'hA000_0002);
    idle();
    chk("f4_if_rvalid", a_if_rvalid, 0);

    // Collision: data wins, fetch follows
    drive(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
    chk("c0_d_gnt", a_d_gnt, 1);
    chk("c0_if_gnt", a_if_gnt, 0);
    chk("c0_mem_addr", 32'(a_mem_addr), 8);
    drive(1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("c1_if_gnt", a_if_gnt, 1);
    chk("c1_mem_addr", 32'(a_mem_addr), 4);
    chk("c1_d_rvalid", a_d_rvalid, 1);
    chk("c1_d_rdata", a_d_rdata, 32'hA000_0008);
    idle();
    chk("c2_if_rvalid", a_if_rvalid, 1);
    chk("c2_d_rvalid", a_d_rvalid, 0);
    chk("c2_if_rdata", a_if_rdata, 32'hA000_0004);

    // Half-word store then read back
    drive(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
    chk("s0_mem_we", 32'(a_mem_we), 32'h3);
    chk("s0_mem_addr", 32'(a_mem_addr), 32'h10);
    chk("s0_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
    chk("s1_d_gnt", a_d_gnt, 1);
    chk("s1_mem_we", 32'(a_mem_we), 0);
    chk("s1_no_wr_resp", a_d_rvalid, 0);
    idle();
    chk("s2_d_rvalid", a_d_rvalid, 1);
    chk("s2_d_rdata", a_d_rdata, 32'hA000_BEEF);
    idle();

    // Latency 2: alternating IF/D reads
    drive(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("l0_b_if_gnt", b_if_gnt, 1);
    chk("l0_b_rvalid", {b_if_rvalid, b_d_rvalid}, 0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
    chk("l1_b_d_gnt", b_d_gnt, 1);
    chk("l1_b_rvalid", {b_if_rvalid, b_d_rvalid}, 0);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("l2_b_rvalid", {b_if_rvalid, b_d_rvalid}, 2'b10);
    chk("l2_b_if_rdata", b_if_rdata, 32'hA000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hC, 32'h0);
    chk("l3_b_rvalid", {b_if_rvalid, b_d_rvalid}, 2'b01);
    chk("l3_b_d_rdata", b_d_rdata, 32'hA000_0001);
    idle();
    chk("l4_b_rvalid", {b_if_rvalid, b_d_rvalid}, 2'b10);
    chk("l4_b_if_rdata", b_if_rdata, 32'hA000_0002);
    idle();
    chk("l5_b_rvalid", {b_if_rvalid, b_d_rvalid}, 2'b01);
    chk("l5_b_d_rdata", b_d_rdata, 32'hA000_0003);
    idle();
    chk("l6_b_rvalid", {b_if_rvalid, b_d_rvalid}, 0);

    // Reset while a latency-2 data read is in flight
    drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
    chk("r0_b_d_gnt", b_d_gnt, 1);
    drive(1'b1, 1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
    chk("r1_gnt", {a_if_gnt, a_d_gnt, b_if_gnt, b_d_gnt}, 0);
    chk("r1_mem_en", {a_mem_en, b_mem_en}, 0);
    chk("r1_b_d_rvalid", b_d_rvalid, 0);
    drive(1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("r2_if_gnt", {a_if_gnt, b_if_gnt}, 2'b11);
    chk("r2_b_d_rvalid", b_d_rvalid, 0);
    idle();
    chk("r3_b_d_rvalid", b_d_rvalid, 0);
    chk("r3_a_if_rdata", a_if_rdata, 32'hA000_0004);
    idle();
    chk("r4_b_d_rvalid", b_d_rvalid, 0);
    chk("r4_b_if_rvalid", b_if_rvalid, 1);
    chk("r4_b_if_rdata", b_if_rdata, 32'hA000_0004);

    // Both ports held high
    idle();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 32'h30, 1'b1, 4'h0, 32'h50, 32'h0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("starve_if_gnt", {a_if_gnt, b_if_gnt}, (k % 5 == 4) ? 2'b11 : 2'b00);
      chk("starve_d_gnt", {a_d_gnt, b_d_gnt}, (k % 5 == 4) ? 2'b00 : 2'b11);
`else
      chk("starve_if_gnt", {a_if_gnt, b_if_gnt}, 2'b00);
      chk("starve_d_gnt", {a_d_gnt, b_d_gnt}, 2'b11);
`endif
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
